// File: rtl/checker_pkg.sv
// Shared types for the end-of-test store checker: verdict states and fail reasons.
// Also holds the saturating increment used by the accepted-store counter.
package checker_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      PASS = 2'd1,
      FAIL = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      NONE       = 3'd0,
      WRONG_DATA = 3'd1,
      BAD_ADDR   = 3'd2,
      EBREAK     = 3'd3,
      ECALL      = 3'd4,
      TIMEOUT    = 3'd5
   } fail_code_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/store_log_fifo.sv
// Show-ahead FIFO holding accepted stores; the head entry is presented combinationally.
// A push into a full FIFO is only taken when a pop frees a slot on the same edge.
module store_log_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   // One extra pointer bit distinguishes full from empty.
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
   end

   // Stale storage is masked so the head reads zero whenever nothing is queued.
   assign dout = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/store_result_checker.sv
// End-of-test checker: classifies stores and traps into a terminal PASS/FAIL verdict,
// runs a watchdog, counts accepted stores and logs them for later inspection.
module store_result_checker
   import checker_pkg::*;
#(
   parameter logic [31:0] PASS_ADDR      = 32'd100,
   parameter logic [31:0] PASS_DATA      = 32'd25,
   parameter logic [31:0] SCRATCH_ADDR   = 32'd96,
   parameter int          TIMEOUT_CYCLES = 10000,
   parameter int          LOG_DEPTH      = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemWrite,
   input  logic [31:0] DataAddr,
   input  logic [31:0] WriteData,
   input  logic        Ecall,
   input  logic        Ebreak,
   output logic        done,
   output logic        pass,
   output logic        fail,
   output logic [2:0]  fail_code,
   output logic [15:0] store_count,
   output logic        log_valid,
   input  logic        log_ready,
   output logic [31:0] log_addr,
   output logic [31:0] log_data,
   output logic        log_overflow
);

   localparam int            CW      = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CYC_ONE = 1;
   localparam logic [CW-1:0] CYC_END = CW'(TIMEOUT_CYCLES - 1);

   state_t        state_reg, state_next;
   fail_code_t    code_reg, code_next;
   logic [CW-1:0] cyc_reg, cyc_next;
   logic [15:0]   store_count_reg;
   logic          overflow_reg;

   logic          accept;
   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_pop;
   logic [63:0]   fifo_head;

   assign accept   = MemWrite && (state_reg == RUN);
   assign fifo_pop = !fifo_empty && log_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= RUN;
         code_reg  <= NONE;
         cyc_reg   <= '0;
      end else begin
         state_reg <= state_next;
         code_reg  <= code_next;
         cyc_reg   <= cyc_next;
      end
   end

   // Verdict rules are evaluated in priority order; only RUN can change state.
   always_comb begin
      state_next = state_reg;
      code_next  = code_reg;
      cyc_next   = cyc_reg;
      if (state_reg == RUN) begin
         if (accept && DataAddr == PASS_ADDR && WriteData == PASS_DATA) begin
            state_next = PASS;
         end else if (accept && DataAddr == PASS_ADDR) begin
            state_next = FAIL;
            code_next  = WRONG_DATA;
         end else if (accept && DataAddr != SCRATCH_ADDR) begin
            state_next = FAIL;
            code_next  = BAD_ADDR;
         end else if (Ebreak) begin
            state_next = FAIL;
            code_next  = EBREAK;
         end else if (Ecall) begin
            state_next = FAIL;
            code_next  = ECALL;
         end else if (cyc_reg == CYC_END) begin
            state_next = FAIL;
            code_next  = TIMEOUT;
         end else begin
            cyc_next = cyc_reg + CYC_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         store_count_reg <= '0;
         overflow_reg    <= 1'b0;
      end else begin
         if (accept) store_count_reg <= sat_inc16(store_count_reg);
         // A full log only drops the store when no slot is freed on this edge.
         if (accept && fifo_full && !fifo_pop) overflow_reg <= 1'b1;
      end
   end

   store_log_fifo #(
      .DEPTH(LOG_DEPTH),
      .WIDTH(64)
   ) u_log (
      .clk  (clk),
      .rst  (rst),
      .push (accept),
      .pop  (fifo_pop),
      .din  ({DataAddr, WriteData}),
      .dout (fifo_head),
      .full (fifo_full),
      .empty(fifo_empty)
   );

   assign pass         = (state_reg == PASS);
   assign fail         = (state_reg == FAIL);
   assign done         = pass | fail;
   assign fail_code    = code_reg;
   assign store_count  = store_count_reg;
   assign log_valid    = !fifo_empty;
   assign log_addr     = fifo_head[63:32];
   assign log_data     = fifo_head[31:0];
   assign log_overflow = overflow_reg;

endmodule

// File: doc/store_result_checker.md
# store_result_checker

Synthesizable end-of-test checker sitting directly downstream of `top`, consuming its store bus (`MemWrite`, `DataAddr`, `WriteData`) and its `Ecall`/`Ebreak` trap flags. It classifies every store, latches a terminal PASS/FAIL verdict with a fail code, and enforces a watchdog timeout. It buffers accepted stores in a small log FIFO, drained by a ready/valid port, so FPGA and bench harnesses can inspect the store stream after the fact.

## Interface
- `PASS_ADDR`, 32'd100: store address that ends the test.
- `PASS_DATA`, 32'd25: required data at `PASS_ADDR` for PASS.
- `SCRATCH_ADDR`, 32'd96: only other address allowed to receive stores.
- `TIMEOUT_CYCLES`, 10000: cycles in RUN before watchdog FAIL; must be ≥2.
- `LOG_DEPTH`, 8: log FIFO entries; must be a power of two, ≥2.
- `clk`  in  1  processor clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `MemWrite`  in  1  store strobe from `top`.
- `DataAddr`  in  32  store address.
- `WriteData`  in  32  store data.
- `Ecall`, `Ebreak`  in  1 each  trap flags from `top`.
- `done`  out  1  verdict latched.
- `pass`  out  1  verdict is PASS.
- `fail`  out  1  verdict is FAIL.
- `fail_code`  out  3  reason; valid when `fail`=1.
- `store_count`  out  16  accepted stores, saturating.
- `log_valid`  out  1  FIFO non-empty.
- `log_ready`  in  1  consumer pop request.
- `log_addr`, `log_data`  out  32 each  head entry (show-ahead).
- `log_overflow`  out  1  sticky: an accepted store was dropped because the FIFO was full.

## Operation
- States: RUN (after reset), PASS, FAIL. PASS and FAIL are terminal until reset.
- A store is "accepted" when `MemWrite`=1 at a rising edge in RUN. Stores in PASS/FAIL are ignored: not counted, not logged.
- RUN edge evaluation, in priority order:
  1. Accepted store with `DataAddr`==`PASS_ADDR` and `WriteData`==`PASS_DATA` → PASS.
  2. Accepted store with `DataAddr`==`PASS_ADDR` and any other data → FAIL, code 1 (WRONG_DATA).
  3. Accepted store with an address other than `PASS_ADDR`/`SCRATCH_ADDR` → FAIL, code 2 (BAD_ADDR).
  4. `Ebreak`=1 → FAIL, code 3 (EBREAK).
  5. `Ecall`=1 → FAIL, code 4 (ECALL).
  6. Cycle counter == `TIMEOUT_CYCLES`-1 → FAIL, code 5 (TIMEOUT).
  7. Otherwise stay in RUN; the cycle counter increments.
- An accepted store to `SCRATCH_ADDR` together with a trap in the same edge → trap wins (rule 4/5). The store is still counted and logged.
- Every accepted store, including the terminating one, increments `store_count` (saturates at 16'hFFFF) and pushes {addr, data} to the log.
- Log FIFO push when full: dropped and `log_overflow` set, unless a pop occurs in the same edge, in which case the push succeeds.
- Pop occurs when `log_valid` && `log_ready`. Popping continues normally in PASS/FAIL.
- `done` = `pass` | `fail`. `pass` and `fail` are never both 1. `fail_code` = 0 whenever `fail`=0.

## Timing
- Reset values (asynchronous on `rst` low): state RUN; `done`/`pass`/`fail`/`log_overflow`/`log_valid` = 0; `fail_code`, `store_count`, cycle counter and FIFO pointers = 0; `log_addr`/`log_data` = 0.
- Reset asserted mid-test or mid-drain clears everything immediately, including FIFO contents. Operation resumes on the first rising edge after `rst` deasserts.
- Verdict latency: `done`/`pass`/`fail`/`fail_code` are registered and become visible right after the edge that samples the terminating event.
- `store_count` is visible right after the sampling edge.
- FIFO push-to-`log_valid`: 1 cycle. Head data is valid in the same cycle as `log_valid`. After a pop, the next entry is presented right after the popping edge.
- Watchdog: with no other event, `fail` rises right after the `TIMEOUT_CYCLES`-th edge following reset release.

## Structure
- Package `checker_pkg`: `state_t` enum {RUN, PASS, FAIL} and `fail_code_t` 3-bit enum {NONE=0, WRONG_DATA=1, BAD_ADDR=2, EBREAK=3, ECALL=4, TIMEOUT=5}.
- Sub-module `store_log_fifo`: parameterized depth and width 64, show-ahead, async active-low reset, with push/pop/full/empty ports. The checker owns the overflow flag.

## Test plan
- Stores (96, 7), then (100, 25) → `pass`=1 after the second edge, `store_count`=2, log pops (96, 7) then (100, 25), `log_overflow`=0.
- Store (100, 24) → `fail`=1, `fail_code`=1. A later store (100, 25) is ignored: `store_count` stays 1.
- Store (104, 25) → `fail_code`=2. Separately: `Ebreak`=1 with store (96, 1) in the same edge → `fail_code`=3, `store_count`=1.
- `TIMEOUT_CYCLES`=16, no stores or traps → `fail` rises right after edge 16 with `fail_code`=5. Not risen after edge 15.
- `LOG_DEPTH`=4, `log_ready`=0, five (96, n) stores → 4 entries held, `log_overflow`=1. Repeat with `log_ready`=1 on the fifth edge → no overflow.
- `rst` pulsed low mid-drain after (96, 3) → all outputs 0 immediately, `log_valid`=0. The test then passes normally with (100, 25).
